// File: rtl/execute_stage.sv
// Execute stage: ALU, condition-code register and the execute/memory output register.
// Optional macro EX_FWD_EN enables execute->execute operand forwarding from the output register.
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 11,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] op_a_in,
  input  logic [DATA_W-1:0] op_b_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [2:0]        func_in,
  input  logic [ADDR_W-1:0] src1_addr_in,
  input  logic [ADDR_W-1:0] src2_addr_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [2:0]        ccr_out
);

  localparam int REG_WRITE = 0;
  localparam int ALU_EN    = 3;
  localparam int FLAG_EN   = 4;
  localparam int SETC      = 5;
  localparam int CLRC      = 6;

  localparam logic [DATA_W:0] WIDE_ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [DATA_W:0]   aluWide;
  logic              carryValid;
  logic [DATA_W-1:0] resultNext;
  logic [2:0]        ccrNext;

`ifdef EX_FWD_EN
  // A bubble in the output register has reg_write clear, so it never forwards.
  always_comb begin
    opA = op_a_in;
    opB = op_b_in;
    if (ctrl_out[REG_WRITE] && (wr_addr_out == src1_addr_in))
      opA = result_out;
    if (ctrl_out[REG_WRITE] && (wr_addr_out == src2_addr_in))
      opB = result_out;
  end
`else
  logic unusedSrcAddr;
  assign unusedSrcAddr = ^{src1_addr_in, src2_addr_in};
  always_comb begin
    opA = op_a_in;
    opB = op_b_in;
  end
`endif

  // 17-bit arithmetic: bit DATA_W is carry for add/inc and borrow for sub/dec.
  always_comb begin
    aluWide    = '0;
    carryValid = 1'b0;
    case (func_in)
      3'b000: aluWide = {1'b0, ~opA};
      3'b001: begin aluWide = {1'b0, opA} + WIDE_ONE;    carryValid = 1'b1; end
      3'b010: begin aluWide = {1'b0, opA} - WIDE_ONE;    carryValid = 1'b1; end
      3'b011: begin aluWide = {1'b0, opA} + {1'b0, opB}; carryValid = 1'b1; end
      3'b100: begin aluWide = {1'b0, opA} - {1'b0, opB}; carryValid = 1'b1; end
      3'b101: aluWide = {1'b0, opA & opB};
      3'b110: aluWide = {1'b0, opA | opB};
      default: aluWide = {1'b0, opB};
    endcase
  end

  assign resultNext = ctrl_in[ALU_EN] ? aluWide[DATA_W-1:0] : opA;

  // setc/clrc apply even when the ALU flags are not being written.
  always_comb begin
    ccrNext = ccr_out;
    if (ctrl_in[ALU_EN] && ctrl_in[FLAG_EN]) begin
      ccrNext[0] = (aluWide[DATA_W-1:0] == '0);
      ccrNext[1] = aluWide[DATA_W-1];
      if (carryValid)
        ccrNext[2] = aluWide[DATA_W];
    end
    if (ctrl_in[SETC])
      ccrNext[2] = 1'b1;
    else if (ctrl_in[CLRC])
      ccrNext[2] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_out       <= '0;
      result_out     <= '0;
      store_data_out <= '0;
      wr_addr_out    <= '0;
      ccr_out        <= '0;
    end else if (!stall) begin
      if (flush) begin
        ctrl_out       <= '0;
        result_out     <= '0;
        store_data_out <= '0;
        wr_addr_out    <= '0;
      end else begin
        ctrl_out       <= ctrl_in;
        result_out     <= resultNext;
        store_data_out <= opB;
        wr_addr_out    <= wr_addr_in;
        ccr_out        <= ccrNext;
      end
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute stage of the 16-bit five-stage pipeline. It sits directly downstream of the decode/execute pipeline register and consumes its control word, two operands, destination address and function code. It performs the ALU operation and maintains the condition-code register (CCR). It also registers the result, control word and destination into its own execute/memory output register, which feeds the memory stage.

Parameters:
DATA_W, 16, operand/result width
CTRL_W, 11, control-word width (matches decode output)
ADDR_W, 3, register-file address width

Ports:
clk  in  1  stage clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold all output registers and CCR
flush  in  1  load a bubble into the output register
ctrl_in  in  CTRL_W  control word from decode/execute register
op_a_in  in  DATA_W  read data 1 (Rsrc1)
op_b_in  in  DATA_W  read data 2 (Rsrc2)
wr_addr_in  in  ADDR_W  destination register
func_in  in  3  ALU function code
src1_addr_in  in  ADDR_W  Rsrc1 address (used only with EX_FWD_EN)
src2_addr_in  in  ADDR_W  Rsrc2 address (used only with EX_FWD_EN)
ctrl_out  out  CTRL_W  registered control word to memory stage
result_out  out  DATA_W  registered ALU result
store_data_out  out  DATA_W  registered op_b (data to be stored)
wr_addr_out  out  ADDR_W  registered destination
ccr_out  out  3  {C,N,Z} condition-code register

Behaviour:
- Control bits used: ctrl[0]=reg_write, ctrl[3]=alu_en, ctrl[4]=flag_en, ctrl[5]=setc, ctrl[6]=clrc. All other bits pass through untouched.
- Function codes: 000 NOT A; 001 A+1; 010 A-1; 011 A+B; 100 A-B; 101 A&B; 110 A|B; 111 pass B.
- Arithmetic is 17-bit internally; result is the low 16 bits.
  - C = bit 16 for INC and ADD.
  - C = borrow (A<B unsigned, or A==0 for DEC) for SUB and DEC.
  - Logic ops and pass leave C unchanged.
- Z = (result==0); N = result[15].
- alu_en=0 → result = op_a_in (pass A); the CCR is not updated.
- CCR update happens on the same edge as the output register, when alu_en&flag_en.
- setc/clrc force C to 1/0 on the edge. They override the ALU-generated C; setc wins if both are set.
- Latency: 1 cycle; inputs present before edge N appear on the outputs after edge N.
- Priority on each edge: reset > stall > flush > normal.
  - reset: all outputs and CCR become 0.
  - stall: outputs and CCR hold their values; flush is ignored while stall=1.
  - flush: ctrl_out, wr_addr_out, result_out and store_data_out become 0 (bubble); CCR holds.
- Reset asserted mid-stream clears everything on that edge. The first valid instruction may arrive on the edge after reset deasserts.
- A control word of all zeros is a NOP: it writes no register and leaves flags unchanged.

Optional Feature:
Macro EX_FWD_EN.
- Defined: execute→execute forwarding.
  - If ctrl_out[0]=1 and wr_addr_out==src1_addr_in, operand A uses result_out instead of op_a_in.
  - The same rule applies independently to operand B with src2_addr_in.
  - store_data_out uses the forwarded B.
  - A bubble (ctrl_out[0]=0) never forwards.
- Undefined: src1_addr_in and src2_addr_in are ignored; operands always come from op_a_in and op_b_in. The port list is identical in both builds.

Test Plan:
1. reset=1 for 2 cycles with nonzero inputs → all outputs 0 and ccr_out=000. Deassert reset; ADD with A=3, B=4, ctrl=0x019 → next cycle result_out=7, ccr_out=000.
2. ADD A=0xFFFF, B=0x0001, flag_en=1 → result_out=0x0000, ccr_out={C=1,N=0,Z=1}. Then SUB A=1, B=2 → result_out=0xFFFF, ccr_out={1,1,0}.
3. AND A=0x8000, B=0xFFFF after C=1 → result_out=0x8000, C stays 1, N=1. Then setc=clrc=1 on a NOP → C=1; clrc alone → C=0.
4. stall=1 for 3 cycles while inputs change → outputs and ccr_out frozen. stall=1 and flush=1 together → hold. flush alone → ctrl_out=0, wr_addr_out=0, CCR unchanged.
5. Back-to-back: ADD R1=5+5, then ADD with src1=R1 and stale op_a_in=0, op_b_in=1.
   - EX_FWD_EN defined → result_out=11.
   - EX_FWD_EN undefined → result_out=1.
   - Repeat with a bubble in between → 1 in both builds.
6. reset asserted in the same cycle as a valid ADD → outputs 0 next cycle; CCR 000.
